// File: rtl/spec_epoch_tracker_if.sv
// rtl/spec_epoch_tracker_if.sv - decode/resolve/squash/query bundle for the epoch tracker
interface spec_epoch_tracker_if #(
    parameter int YROT_WIDTH  = 9,
    parameter int NUM_DECODE  = 4,
    parameter int NUM_RESOLVE = 2,
    parameter int NUM_QUERY   = 4
);
    localparam int E = YROT_WIDTH + 1;

    logic [NUM_DECODE-1:0]    dec_valid;
    logic [NUM_DECODE-1:0]    dec_branch;
    logic [YROT_WIDTH-1:0]    rob_tail;
    logic                     rob_wrap;
    logic                     dec_ready;
    logic [NUM_DECODE*E-1:0]  dec_epoch;
    logic [NUM_RESOLVE-1:0]   res_valid;
    logic [NUM_RESOLVE*E-1:0] res_yrot;
    logic                     squash_valid;
    logic [E-1:0]             squash_yrot;
    logic                     vp_valid;
    logic [E-1:0]             vp_epoch;
    logic [NUM_QUERY*E-1:0]   q_yrot;
    logic [NUM_QUERY-1:0]     q_safe;

    modport master (
        output dec_valid, dec_branch, rob_tail, rob_wrap, res_valid, res_yrot,
               squash_valid, squash_yrot, q_yrot,
        input  dec_ready, dec_epoch, vp_valid, vp_epoch, q_safe
    );

    modport slave (
        input  dec_valid, dec_branch, rob_tail, rob_wrap, res_valid, res_yrot,
               squash_valid, squash_yrot, q_yrot,
        output dec_ready, dec_epoch, vp_valid, vp_epoch, q_safe
    );
endinterface

// File: rtl/spec_epoch_tracker.sv
// rtl/spec_epoch_tracker.sv - in-flight branch queue publishing speculation epochs and visibility point
module spec_epoch_tracker #(
    parameter int YROT_WIDTH  = 9,
    parameter int NUM_DECODE  = 4,
    parameter int NUM_RESOLVE = 2,
    parameter int NUM_QUERY   = 4,
    parameter int BQ_DEPTH    = 16
) (
    input logic                 clk,
    input logic                 reset,
    spec_epoch_tracker_if.slave bus
);
    localparam int E  = YROT_WIDTH + 1;
    localparam int LW = $clog2(BQ_DEPTH);
    localparam int CW = $clog2(BQ_DEPTH + 1);

    logic [E-1:0]          ent_epoch [BQ_DEPTH];
    logic [BQ_DEPTH-1:0]   ent_res;
    logic [LW-1:0]         head;
    logic [LW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [E-1:0]          last_epoch;
    logic [NUM_QUERY-1:0]  q_safe_r;

    logic [E-1:0]          slot_epoch [NUM_DECODE];
    logic [NUM_DECODE*E-1:0] dec_epoch_w;
    logic [E-1:0]          run_epoch;
    logic [YROT_WIDTH:0]   slot_sum;
    logic [LW-1:0]         wr_pos [NUM_DECODE];
    logic [CW-1:0]         n_br;
    logic [LW-1:0]         off [BQ_DEPTH];
    logic [BQ_DEPTH-1:0]   in_q;
    logic [BQ_DEPTH-1:0]   keep;
    logic [CW-1:0]         surv_cnt;
    logic [CW-1:0]         n_pop;
    logic [LW-1:0]         pop_pos;
    logic                  pop_run;
    logic                  dec_ready_w;
    logic                  accept;
    logic                  vp_valid_w;
    logic [E-1:0]          vp_epoch_w;

    function automatic logic younger(input logic [E-1:0] a, input logic [E-1:0] b);
        if (a[E-1] == b[E-1])
            return a[YROT_WIDTH-1:0] > b[YROT_WIDTH-1:0];
        else
            return a[YROT_WIDTH-1:0] < b[YROT_WIDTH-1:0];
    endfunction

    // Each slot inherits the youngest branch at or before it; the carry out of the
    // index add is exactly the "wrapped past 0" condition for that slot.
    always_comb begin
        slot_sum    = '0;
        dec_epoch_w = '0;
        run_epoch   = last_epoch;
        for (int k = 0; k < NUM_DECODE; k++) begin
            slot_sum      = {1'b0, bus.rob_tail} + E'(k);
            slot_epoch[k] = {bus.rob_wrap ^ slot_sum[YROT_WIDTH], slot_sum[YROT_WIDTH-1:0]};
            if (bus.dec_valid[k] && bus.dec_branch[k])
                run_epoch = slot_epoch[k];
            dec_epoch_w[k*E +: E] = run_epoch;
        end
    end

    always_comb begin
        n_br = '0;
        for (int k = 0; k < NUM_DECODE; k++) begin
            wr_pos[k] = tail + n_br[LW-1:0];
            if (bus.dec_valid[k] && bus.dec_branch[k])
                n_br = n_br + CW'(1);
        end
    end

    // keep marks occupied entries that survive a squash (all occupied ones otherwise).
    always_comb begin
        surv_cnt = '0;
        for (int e = 0; e < BQ_DEPTH; e++) begin
            off[e]  = LW'(e) - head;
            in_q[e] = CW'(off[e]) < count;
            keep[e] = in_q[e] && !(bus.squash_valid && younger(ent_epoch[e], bus.squash_yrot));
            if (keep[e])
                surv_cnt = surv_cnt + CW'(1);
        end
    end

    always_comb begin
        n_pop   = '0;
        pop_pos = head;
        pop_run = 1'b1;
        for (int j = 0; j < NUM_RESOLVE; j++) begin
            pop_pos = head + LW'(j);
            if (pop_run && keep[pop_pos] && ent_res[pop_pos])
                n_pop = n_pop + CW'(1);
            else
                pop_run = 1'b0;
        end
    end

    assign dec_ready_w = !bus.squash_valid && (count <= CW'(BQ_DEPTH - NUM_DECODE));
    assign accept      = dec_ready_w && (|bus.dec_valid);
    assign vp_valid_w  = (count != '0);
    assign vp_epoch_w  = vp_valid_w ? ent_epoch[head] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_res    <= '0;
            last_epoch <= '0;
            q_safe_r   <= '0;
        end else begin
            for (int i = 0; i < NUM_QUERY; i++)
                q_safe_r[i] <= !vp_valid_w || younger(vp_epoch_w, bus.q_yrot[i*E +: E]);

            for (int e = 0; e < BQ_DEPTH; e++)
                for (int r = 0; r < NUM_RESOLVE; r++)
                    if (keep[e] && bus.res_valid[r] && ent_epoch[e] == bus.res_yrot[r*E +: E])
                        ent_res[e] <= 1'b1;

            head <= head + n_pop[LW-1:0];

            if (bus.squash_valid) begin
                tail       <= head + surv_cnt[LW-1:0];
                count      <= surv_cnt - n_pop;
                last_epoch <= bus.squash_yrot;
            end else if (accept) begin
                for (int k = 0; k < NUM_DECODE; k++) begin
                    if (bus.dec_valid[k] && bus.dec_branch[k]) begin
                        ent_epoch[wr_pos[k]] <= slot_epoch[k];
                        ent_res[wr_pos[k]]   <= 1'b0;
                    end
                end
                tail       <= tail + n_br[LW-1:0];
                count      <= count - n_pop + n_br;
                last_epoch <= dec_epoch_w[(NUM_DECODE-1)*E +: E];
            end else begin
                count <= count - n_pop;
            end
        end
    end

    assign bus.dec_ready = dec_ready_w;
    assign bus.dec_epoch = dec_epoch_w;
    assign bus.vp_valid  = vp_valid_w;
    assign bus.vp_epoch  = vp_epoch_w;
    assign bus.q_safe    = q_safe_r;
endmodule
